// File: rtl/imsic_msi_tx.sv
// IMSIC MSI transmitter: decodes seteipnum writes, queues them and replays each as a
// timed one-hot valid pulse with a stable setipnum. Optional macro: IMSIC_MSI_TX_SETEIPNUM_BE_EN.
module imsic_msi_tx #(
   parameter int NR_INTP_FILES = 7,
   parameter int NR_HARTS      = 4,
   parameter int NR_SRC        = 32,
   parameter int FIFO_DEPTH    = 4,
   parameter int HOLD_CYCLES   = 4,
   parameter int GAP_CYCLES    = 4,
   parameter int ADDR_WIDTH    = 32,
   localparam int NR_SRC_WIDTH   = $clog2(NR_SRC),
   localparam int NR_TOTAL_INTFS = NR_HARTS * NR_INTP_FILES,
   localparam int PAGE_W         = $clog2(NR_TOTAL_INTFS)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_wr_vld,
   output logic                      o_wr_rdy,
   input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
   input  logic [31:0]               i_wr_data,
   output logic [NR_SRC_WIDTH-1:0]   o_setipnum,
   output logic [NR_TOTAL_INTFS-1:0] o_setipnum_vld,
   output logic                      o_busy,
   output logic [7:0]                o_drop_cnt
);

   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W   = PAGE_W + NR_SRC_WIDTH;
   localparam int PAGE_HI_W = ADDR_WIDTH - 12;
   localparam int CNT_MAX   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [PAGE_HI_W-1:0] PAGE_LIMIT = PAGE_HI_W'(NR_TOTAL_INTFS);
   localparam logic [PTR_W:0]       DEPTH_V    = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]     HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]     GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ASSERT, GAP} state_t;

   state_t                  state, next_state;
   logic [PAGE_HI_W-1:0]    wr_page;
   logic [11:0]             wr_offset;
   logic [31:0]             eff_data;
   logic                    offset_ok, wr_legal, accept, push, pop;
   logic                    fifo_full, fifo_empty;
   logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr, rd_ptr;
   logic [PTR_W:0]          fifo_cnt;
   logic [PAGE_W-1:0]       file_q;
   logic [CNT_W-1:0]        phase_cnt;

   assign wr_page   = i_wr_addr[ADDR_WIDTH-1:12];
   assign wr_offset = i_wr_addr[11:0];

   // The big-endian alias carries a byte-swapped identity; swap before range checking.
   always_comb begin
      eff_data  = i_wr_data;
      offset_ok = (wr_offset == 12'h000);
`ifdef IMSIC_MSI_TX_SETEIPNUM_BE_EN
      if (wr_offset == 12'h004) begin
         offset_ok = 1'b1;
         eff_data  = {i_wr_data[7:0], i_wr_data[15:8], i_wr_data[23:16], i_wr_data[31:24]};
      end
`endif
   end

   assign wr_legal   = offset_ok && (wr_page < PAGE_LIMIT) &&
                       ((eff_data >> NR_SRC_WIDTH) == 32'd0) && (eff_data != 32'd0);
   assign fifo_full  = (fifo_cnt == DEPTH_V);
   assign fifo_empty = (fifo_cnt == '0);
   assign o_wr_rdy   = ~fifo_full;
   assign accept     = i_wr_vld & ~fifo_full;
   assign push       = accept & wr_legal;
   assign o_busy     = (state != IDLE) | ~fifo_empty;

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {wr_page[PAGE_W-1:0], eff_data[NR_SRC_WIDTH-1:0]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
         else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_drop_cnt <= '0;
      end else if (accept && !wr_legal && o_drop_cnt != 8'hFF) begin
         o_drop_cnt <= o_drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         o_setipnum <= '0;
         file_q     <= '0;
         phase_cnt  <= '0;
      end else begin
         state <= next_state;
         if (pop) {file_q, o_setipnum} <= fifo_mem[rd_ptr];
         if (state == SETUP)                        phase_cnt <= HOLD_LOAD;
         else if (state == ASSERT && phase_cnt == '0) phase_cnt <= GAP_LOAD;
         else if (phase_cnt != '0)                    phase_cnt <= phase_cnt - 1'b1;
      end
   end

   // Valid is decoded from registered state so an async reset clears it at once.
   always_comb begin
      next_state     = state;
      pop            = 1'b0;
      o_setipnum_vld = '0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = SETUP;
            end
         end
         SETUP:  next_state = ASSERT;
         ASSERT: begin
            o_setipnum_vld = NR_TOTAL_INTFS'(1) << file_q;
            if (phase_cnt == '0) next_state = GAP;
         end
         GAP:    if (phase_cnt == '0) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

endmodule
